// File: rtl/la_ppfifo_reader.sv
// la_ppfifo_reader
// Drains a finished logic analyzer capture into a ping-pong FIFO. Core reads
// are paced to the capture RAM read latency. Each sample goes out as one
// 32-bit word into whichever FIFO half is ready, so the host path can upload
// the capture without register polling.

module la_ppfifo_reader #(
   parameter int READ_LATENCY = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic        i_la_finished,
   input  logic [31:0] i_la_read_size,
   input  logic [31:0] i_la_data,
   output logic        o_la_read_strobe,
   input  logic [1:0]  i_write_ready,
   output logic [1:0]  o_write_activate,
   input  logic [23:0] i_write_fifo_size,
   output logic        o_write_strobe,
   output logic [31:0] o_write_data,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_words_sent
);

   localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_GRAB,
      ST_FETCH,
      ST_WAIT,
      ST_RELEASE,
      ST_DONE
   } state_t;

   state_t      r_state;
   logic [3:0]  r_latCnt;
   logic [31:0] r_remaining;
   logic [23:0] r_fifoCnt;
   logic [1:0]  r_writeActivate;
   logic        r_writeStrobe;
   logic        r_laReadStrobe;
   logic [31:0] r_writeData;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_wordsSent;

   logic        w_abort;
   logic [3:0]  w_latDec;
   logic [1:0]  w_grabSel;
   logic        w_halfReady;
   logic [31:0] w_remainingNext;
   logic [23:0] w_fifoCntNext;

   // A transfer is only valid while the reader is armed and the capture is
   // still marked finished; losing either one abandons the drain.
   assign w_abort = !(i_enable && i_la_finished);

   // The latency counter saturates at zero. This lets the RELEASE and GRAB
   // states keep counting down without wrapping when a half-swap is slow.
   assign w_latDec = (r_latCnt != 4'd0) ? (r_latCnt - 4'd1) : 4'd0;

   // Half 0 wins when both halves are offered.
   assign w_grabSel   = i_write_ready[0] ? 2'b01 : 2'b10;
   assign w_halfReady = (i_write_ready != 2'b00) && (i_write_fifo_size != 24'd0);

   assign w_remainingNext = r_remaining - 32'd1;
   assign w_fifoCntNext   = r_fifoCnt + 24'd1;

   // Main reader FSM. Every output is registered here. The strobes default
   // low each cycle, so each one is a single-cycle pulse. busy and done are
   // decoded from the state of the previous cycle, so they lag the state
   // register by one clock.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= ST_IDLE;
         r_latCnt        <= 4'd0;
         r_remaining     <= 32'd0;
         r_fifoCnt       <= 24'd0;
         r_writeActivate <= 2'b00;
         r_writeStrobe   <= 1'b0;
         r_laReadStrobe  <= 1'b0;
         r_writeData     <= 32'd0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_wordsSent     <= 32'd0;
      end else begin
         r_writeStrobe  <= 1'b0;
         r_laReadStrobe <= 1'b0;
         r_busy         <= (r_state != ST_IDLE) && (r_state != ST_DONE);
         r_done         <= (r_state == ST_DONE);

         case (r_state)
            ST_IDLE: begin
               if (i_enable && i_la_finished) begin
                  r_remaining <= i_la_read_size;
                  r_wordsSent <= 32'd0;
                  r_latCnt    <= LAT_LOAD;
                  r_state     <= (i_la_read_size == 32'd0) ? ST_DONE : ST_SETTLE;
               end
            end

            ST_SETTLE: begin
               if (w_abort) begin
                  r_writeActivate <= 2'b00;
                  r_state         <= ST_IDLE;
               end else begin
                  r_latCnt <= w_latDec;
                  if (w_latDec == 4'd0) begin
                     r_state <= ST_GRAB;
                  end
               end
            end

            ST_GRAB: begin
               if (w_abort) begin
                  r_writeActivate <= 2'b00;
                  r_state         <= ST_IDLE;
               end else begin
                  r_latCnt <= w_latDec;
                  if (w_halfReady && (w_latDec == 4'd0)) begin
                     r_writeActivate <= w_grabSel;
                     r_fifoCnt       <= 24'd0;
                     r_state         <= ST_FETCH;
                  end
               end
            end

            ST_FETCH: begin
               if (w_abort) begin
                  r_writeActivate <= 2'b00;
                  r_state         <= ST_IDLE;
               end else begin
                  r_writeData    <= i_la_data;
                  r_writeStrobe  <= 1'b1;
                  r_laReadStrobe <= 1'b1;
                  r_remaining    <= w_remainingNext;
                  r_fifoCnt      <= w_fifoCntNext;
                  r_wordsSent    <= r_wordsSent + 32'd1;
                  r_latCnt       <= LAT_LOAD;
                  if (w_remainingNext == 32'd0) begin
                     r_state <= ST_RELEASE;
                  end else if (w_fifoCntNext == i_write_fifo_size) begin
                     r_state <= ST_RELEASE;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end

            ST_WAIT: begin
               if (w_abort) begin
                  r_writeActivate <= 2'b00;
                  r_state         <= ST_IDLE;
               end else begin
                  r_latCnt <= w_latDec;
                  if (w_latDec == 4'd0) begin
                     r_state <= ST_FETCH;
                  end
               end
            end

            ST_RELEASE: begin
               r_writeActivate <= 2'b00;
               r_latCnt        <= w_latDec;
               r_state         <= (r_remaining == 32'd0) ? ST_DONE : ST_GRAB;
            end

            ST_DONE: begin
               if (!(i_enable && i_la_finished)) begin
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_la_read_strobe = r_laReadStrobe;
   assign o_write_activate = r_writeActivate;
   assign o_write_strobe   = r_writeStrobe;
   assign o_write_data     = r_writeData;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_words_sent     = r_wordsSent;

endmodule

// File: tb/tb_la_ppfifo_reader.sv
// tb_la_ppfifo_reader
// Scoreboard bench for la_ppfifo_reader. The stimulus thread pushes the
// expected write words. A monitor thread pops one entry for every write
// strobe and compares data, channel and strobe spacing.

module tb_la_ppfifo_reader;

   localparam int LAT = 2;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  act;
      int          gap;
      bit          fromStart;
   } expEntry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        laFinished;
   logic [31:0] laReadSize;
   logic [31:0] laData;
   logic        laReadStrobe;
   logic [1:0]  writeReady;
   logic [1:0]  writeActivate;
   logic [23:0] writeFifoSize;
   logic        writeStrobe;
   logic [31:0] writeData;
   logic        busy;
   logic        done;
   logic [31:0] wordsSent;

   logic [31:0] rdPtr;
   logic [31:0] rdPtrD;
   logic [31:0] dataBase;
   logic        ptrClear;

   logic [1:0]  rdyModel;
   int          holdCnt [2];
   logic        autoReady;
   logic        rdyClear;
   logic [1:0]  forcedReady;

   expEntry_t   expQ [$];
   int          testsRun = 0;
   int          failCnt = 0;
   int          cycleCnt = 0;
   int          startCycle = 0;
   int          lastStrobeCycle = 0;
   int          strobeCount = 0;
   int          extraCount = 0;
   bit          allowExtra = 1'b0;
   bit          checkRelease = 1'b0;

   la_ppfifo_reader #(.READ_LATENCY(LAT)) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_enable          (enable),
      .i_la_finished     (laFinished),
      .i_la_read_size    (laReadSize),
      .i_la_data         (laData),
      .o_la_read_strobe  (laReadStrobe),
      .i_write_ready     (writeReady),
      .o_write_activate  (writeActivate),
      .i_write_fifo_size (writeFifoSize),
      .o_write_strobe    (writeStrobe),
      .o_write_data      (writeData),
      .o_busy            (busy),
      .o_done            (done),
      .o_words_sent      (wordsSent)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter, used to measure strobe spacing and start latency
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Capture RAM model: each read strobe advances the pointer, and the word
   // appears on laData LAT cycles after the strobe
   always @(posedge clk) begin
      if (ptrClear) rdPtr <= 32'd0;
      else if (laReadStrobe) rdPtr <= rdPtr + 32'd1;
      rdPtrD <= rdPtr;
   end
   assign laData = dataBase + rdPtrD;

   // Host-side half model: a half stops being ready while it is owned, and
   // it becomes ready again a few cycles after it is released
   always @(posedge clk) begin
      for (int b = 0; b < 2; b++) begin
         if (rdyClear) begin
            rdyModel[b] <= 1'b1;
            holdCnt[b]  <= 0;
         end else if (writeActivate[b]) begin
            rdyModel[b] <= 1'b0;
            holdCnt[b]  <= 6;
         end else if (holdCnt[b] > 0) begin
            holdCnt[b] <= holdCnt[b] - 1;
            if (holdCnt[b] == 1) rdyModel[b] <= 1'b1;
         end
      end
   end
   assign writeReady = autoReady ? rdyModel : forcedReady;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCnt++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   task automatic pushExpected(input logic [31:0] data, input logic [1:0] act, input int gap, input bit fromStart);
      expEntry_t e;
      e.data = data;
      e.act = act;
      e.gap = gap;
      e.fromStart = fromStart;
      expQ.push_back(e);
   endtask

   // The core's finished flag is registered, so raising it here takes effect
   // at the next rising edge. Start latency is measured from that edge.
   task automatic applyStimulus(input logic [31:0] size, input logic [23:0] fifoSize);
      laReadSize    = size;
      writeFifoSize = fifoSize;
      enable        = 1'b1;
      laFinished    = 1'b1;
      startCycle    = cycleCnt + 1;
   endtask

   task automatic clearModel();
      ptrClear = 1'b1;
      rdyClear = 1'b1;
      @(negedge clk);
      @(negedge clk);
      ptrClear = 1'b0;
      rdyClear = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      for (int i = 0; i < budget && !done; i++) @(negedge clk);
      #1;
      checkOutput("doneReached", done, 1);
      checkOutput("scoreboardEmpty", expQ.size(), 0);
   endtask

   task automatic endTransfer();
      laFinished = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("idleBusy", busy, 0);
      checkOutput("idleDone", done, 0);
   endtask

   task automatic monitorLoop();
      expEntry_t  e;
      logic       prevStrobe;
      logic [1:0] prevAct;
      prevStrobe = 1'b0;
      prevAct = 2'b00;
      forever begin
         @(negedge clk);
         if (writeStrobe) begin
            strobeCount++;
            checkOutput("readStrobeCoincident", laReadStrobe, 1);
            if (expQ.size() > 0) begin
               e = expQ.pop_front();
               checkOutput("writeData", writeData, e.data);
               checkOutput("writeActivate", writeActivate, e.act);
               if (e.gap > 0) begin
                  if (e.fromStart) checkOutput("startLatency", 64'(cycleCnt - startCycle), 64'(e.gap));
                  else checkOutput("strobeGap", 64'(cycleCnt - lastStrobeCycle), 64'(e.gap));
               end
            end else if (allowExtra) begin
               extraCount++;
            end else begin
               checkOutput("unexpectedStrobe", writeStrobe, 0);
            end
            lastStrobeCycle = cycleCnt;
         end else if (laReadStrobe) begin
            checkOutput("readStrobeAlone", laReadStrobe, 0);
         end
         if (checkRelease && (prevAct != 2'b00) && (writeActivate == 2'b00))
            checkOutput("releaseAfterStrobe", prevStrobe, 1);
         prevStrobe = writeStrobe;
         prevAct = writeActivate;
      end
   endtask

   // Watchdog so that the bench always terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      int sc;
      int stallErr;

      rst = 1'b1; enable = 1'b0; laFinished = 1'b0; laReadSize = 32'd0;
      writeFifoSize = 24'd0; dataBase = 32'd0; ptrClear = 1'b1; rdyClear = 1'b1;
      autoReady = 1'b0; forcedReady = 2'b00;
      fork monitorLoop(); join_none

      repeat (3) @(negedge clk);
      checkOutput("resetCtrl", {writeActivate, writeStrobe, laReadStrobe, busy, done}, 0);
      checkOutput("resetData", writeData, 0);
      checkOutput("resetWords", wordsSent, 0);
      rst = 1'b0; ptrClear = 1'b0; rdyClear = 1'b0;
      @(negedge clk);

      $display("[TB] basic drain");
      dataBase = 32'd0; forcedReady = 2'b11; checkRelease = 1'b1;
      clearModel();
      for (int i = 0; i < 8; i++) pushExpected(32'(i), 2'b01, (i == 0) ? LAT + 2 : LAT + 1, i == 0);
      applyStimulus(32'd8, 24'd16);
      repeat (3) @(negedge clk);
      checkOutput("busyDuringDrain", busy, 1);
      checkOutput("doneDuringDrain", done, 0);
      waitDone(60);
      checkOutput("basicWords", wordsSent, 8);
      endTransfer();

      $display("[TB] ping-pong split");
      dataBase = 32'd100; autoReady = 1'b1;
      clearModel();
      for (int i = 0; i < 10; i++)
         pushExpected(32'd100 + 32'(i), (i < 4 || i >= 8) ? 2'b01 : 2'b10, (i == 0) ? LAT + 2 : LAT + 1, i == 0);
      applyStimulus(32'd10, 24'd4);
      waitDone(80);
      checkOutput("pingPongWords", wordsSent, 10);
      endTransfer();

      $display("[TB] backpressure");
      dataBase = 32'd200; autoReady = 1'b0; forcedReady = 2'b00;
      clearModel();
      for (int i = 0; i < 6; i++) pushExpected(32'd200 + 32'(i), 2'b10, (i == 0) ? 0 : LAT + 1, 1'b0);
      applyStimulus(32'd6, 24'd16);
      stallErr = 0;
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         if (writeStrobe || (writeActivate != 2'b00)) stallErr++;
      end
      checkOutput("stallQuiet", stallErr, 0);
      forcedReady = 2'b10;
      waitDone(60);
      checkOutput("backpressureWords", wordsSent, 6);
      endTransfer();

      $display("[TB] zero size and no re-arm");
      forcedReady = 2'b11;
      sc = strobeCount;
      applyStimulus(32'd0, 24'd16);
      waitDone(10);
      checkOutput("zeroWords", wordsSent, 0);
      checkOutput("zeroStrobes", strobeCount - sc, 0);
      endTransfer();
      dataBase = 32'd300;
      clearModel();
      for (int i = 0; i < 4; i++) pushExpected(32'd300 + 32'(i), 2'b01, (i == 0) ? LAT + 2 : LAT + 1, i == 0);
      applyStimulus(32'd4, 24'd16);
      waitDone(40);
      sc = strobeCount;
      repeat (30) @(negedge clk);
      checkOutput("noRearmStrobes", strobeCount - sc, 0);
      checkOutput("noRearmDone", done, 1);
      laFinished = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) pushExpected(32'd304 + 32'(i), 2'b01, (i == 0) ? LAT + 2 : LAT + 1, i == 0);
      applyStimulus(32'd2, 24'd16);
      waitDone(30);
      checkOutput("rearmWords", wordsSent, 2);
      endTransfer();

      $display("[TB] abort mid-transfer");
      dataBase = 32'd400; checkRelease = 1'b0; allowExtra = 1'b1; extraCount = 0;
      clearModel();
      for (int i = 0; i < 3; i++) pushExpected(32'd400 + 32'(i), 2'b01, (i == 0) ? LAT + 2 : LAT + 1, i == 0);
      sc = strobeCount;
      applyStimulus(32'd10, 24'd16);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (strobeCount - sc >= 3) break;
      end
      checkOutput("abortThirdWrite", strobeCount - sc, 3);
      enable = 1'b0;
      @(negedge clk);
      checkOutput("abortActivate", writeActivate, 0);
      repeat (3) @(negedge clk);
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortDone", done, 0);
      checkOutput("abortExtraLimit", extraCount <= 1, 1);
      checkOutput("abortWords", wordsSent, 3 + extraCount);
      checkOutput("abortScoreboard", expQ.size(), 0);

      $display("[TB] reset mid-transfer");
      enable = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("preResetBusy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midResetCtrl", {writeActivate, writeStrobe, laReadStrobe, busy, done}, 0);
      checkOutput("midResetData", writeData, 0);
      checkOutput("midResetWords", wordsSent, 0);
      enable = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
      $finish;
   end

endmodule
